// File: rtl/mul_cdb_buffer_pkg.sv
// rtl/mul_cdb_buffer_pkg.sv - shared types and constants for the multiply CDB buffer
package mul_cdb_buffer_pkg;

    localparam int XLEN      = 32;
    localparam int PRF_LEN   = 6;
    localparam int ROB_LEN   = 5;
    localparam int MUL_STAGE = 8;

    typedef enum logic [1:0] {
        ALU_MUL    = 2'd0,
        ALU_MULH   = 2'd1,
        ALU_MULHSU = 2'd2,
        ALU_MULHU  = 2'd3
    } ALU_FUNC;

    typedef struct packed {
        logic               valid;
        ALU_FUNC            func;
        logic               neg;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } MUL_TAG_PACKET;

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } CDB_PACKET;

    // The multiplier only sees magnitudes; the sign is restored on the full
    // double-width product before the low or high half is selected.
    function automatic logic [XLEN-1:0] form_result(input ALU_FUNC f, input logic neg,
                                                    input logic [2*XLEN-1:0] prod);
        logic [2*XLEN-1:0] p;
        p = neg ? (~prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod;
        if (f == ALU_MUL) return p[XLEN-1:0];
        return p[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_cdb_buffer_if.sv
// rtl/mul_cdb_buffer_if.sv - issue, multiplier and CDB signal bundle
interface mul_cdb_buffer_if;
    import mul_cdb_buffer_pkg::*;

    logic               squash;
    logic               issue_valid;
    ALU_FUNC            issue_func;
    logic               issue_neg;
    logic [PRF_LEN-1:0] issue_prf_idx;
    logic [ROB_LEN-1:0] issue_rob_idx;
    logic [XLEN-1:0]    issue_PC;
    logic               issue_ready;
    logic               mul_done;
    logic [2*XLEN-1:0]  mul_product;
    logic               cdb_valid;
    logic [XLEN-1:0]    cdb_value;
    logic [PRF_LEN-1:0] cdb_prf_idx;
    logic [ROB_LEN-1:0] cdb_rob_idx;
    logic [XLEN-1:0]    cdb_PC;
    logic               cdb_grant;

    modport master (
        output squash, issue_valid, issue_func, issue_neg, issue_prf_idx, issue_rob_idx,
               issue_PC, mul_done, mul_product, cdb_grant,
        input  issue_ready, cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC
    );

    modport slave (
        input  squash, issue_valid, issue_func, issue_neg, issue_prf_idx, issue_rob_idx,
               issue_PC, mul_done, mul_product, cdb_grant,
        output issue_ready, cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC
    );

endinterface

// File: rtl/mul_cdb_buffer_result_fifo.sv
// rtl/mul_cdb_buffer_result_fifo.sv - circular queue of finished multiply results
module mul_result_fifo
    import mul_cdb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_squash,
    input  logic                       i_push,
    input  CDB_PACKET                  i_push_data,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_head_valid,
    output CDB_PACKET                  o_head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    CDB_PACKET       r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            w_pop;
    logic            w_kill;

    assign w_kill       = i_reset | i_squash;
    assign w_pop        = i_pop & (r_count != '0);
    assign o_count      = r_count;
    assign o_head_valid = (r_count != '0);
    assign o_head_data  = r_mem[r_head];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clock) begin
        if (w_kill) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge i_clock) begin
        if (!w_kill && i_push) r_mem[r_tail] <= i_push_data;
    end

    // Overflow is only possible if the issuer ignored the credit signal.
    always_ff @(posedge i_clock) begin
        if (!w_kill) assert (!(i_push && !w_pop && r_count == CW'(DEPTH)));
    end

endmodule

// File: rtl/mul_cdb_buffer.sv
// rtl/mul_cdb_buffer.sv - tag delay line, result formation and credit for the multiplier
module mul_cdb_buffer
    import mul_cdb_buffer_pkg::*;
#(
    parameter int STAGE = MUL_STAGE,
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    mul_cdb_buffer_if.slave   bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(STAGE+1);

    MUL_TAG_PACKET  r_pipe [STAGE];
    MUL_TAG_PACKET  w_tail;
    CDB_PACKET      w_push_data;
    CDB_PACKET      w_head_data;
    logic           w_push;
    logic           w_pop;
    logic           w_head_valid;
    logic [CW-1:0]  w_count;
    logic [IW-1:0]  w_inflight;

    assign w_tail = r_pipe[STAGE-1];
    assign w_push = w_tail.valid & bus.mul_done & ~bus.squash;
    assign w_pop  = w_head_valid & bus.cdb_grant;

    // Tag delay line matched to the multiplier latency; it never stalls.
    always_ff @(posedge clock) begin
        if (reset || bus.squash) begin
            for (int i = 0; i < STAGE; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{valid:   bus.issue_valid,
                           func:    bus.issue_func,
                           neg:     bus.issue_neg,
                           prf_idx: bus.issue_prf_idx,
                           rob_idx: bus.issue_rob_idx,
                           PC:      bus.issue_PC};
            for (int i = 1; i < STAGE; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Count of multiplies still inside the multiplier, for the credit check.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < STAGE; i++) w_inflight = w_inflight + IW'(r_pipe[i].valid);
    end

    // Pair the tail tags with the raw product and build the queue entry.
    always_comb begin
        w_push_data         = '0;
        w_push_data.value   = form_result(w_tail.func, w_tail.neg, bus.mul_product);
        w_push_data.prf_idx = w_tail.prf_idx;
        w_push_data.rob_idx = w_tail.rob_idx;
        w_push_data.PC      = w_tail.PC;
    end

    mul_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_squash     (bus.squash),
        .i_push       (w_push),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data)
    );

    // A same-cycle pop is not credited, so every in-flight op already owns a slot.
    assign bus.issue_ready = (int'(w_count) + int'(w_inflight)) < DEPTH;
    assign bus.cdb_valid   = w_head_valid;
    assign bus.cdb_value   = w_head_data.value;
    assign bus.cdb_prf_idx = w_head_data.prf_idx;
    assign bus.cdb_rob_idx = w_head_data.rob_idx;
    assign bus.cdb_PC      = w_head_data.PC;

    // Protocol checks: tags and products must stay aligned, issuer must honor credit.
    always_ff @(posedge clock) begin
        if (!reset && !bus.squash) begin
            assert (!(w_tail.valid && !bus.mul_done));
            assert (!(bus.issue_valid && !bus.issue_ready));
        end
    end

endmodule

// File: tb/tb_mul_cdb_buffer.sv
// tb/tb_mul_cdb_buffer.sv - directed self-checking bench for mul_cdb_buffer
module tb_mul_cdb_buffer;
    import mul_cdb_buffer_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    mul_cdb_buffer_if bus ();

    mul_cdb_buffer #(.STAGE(MUL_STAGE), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Standalone queue instance for the full-queue push+pop case.
    logic      f_push;
    logic      f_pop;
    CDB_PACKET f_data;
    logic [2:0] f_count;
    logic      f_head_valid;
    CDB_PACKET f_head;

    mul_result_fifo #(.DEPTH(4)) u_fifo (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_squash     (1'b0),
        .i_push       (f_push),
        .i_push_data  (f_data),
        .i_pop        (f_pop),
        .o_count      (f_count),
        .o_head_valid (f_head_valid),
        .o_head_data  (f_head)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier model: magnitude product delayed MUL_STAGE cycles, ignores squash.
    logic [31:0]          op_a;
    logic [31:0]          op_b;
    logic [MUL_STAGE-1:0] m_v;
    logic [63:0]          m_p [MUL_STAGE];

    always @(posedge clock) begin
        if (reset) begin
            m_v <= '0;
        end else begin
            m_v    <= {m_v[MUL_STAGE-2:0], bus.issue_valid};
            m_p[0] <= {32'b0, op_a} * {32'b0, op_b};
            for (int i = 1; i < MUL_STAGE; i++) m_p[i] <= m_p[i-1];
        end
    end

    assign bus.mul_done    = m_v[MUL_STAGE-1];
    assign bus.mul_product = m_p[MUL_STAGE-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic drive_issue(input ALU_FUNC f, input logic neg, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] prf,
                               input logic [4:0] rob, input logic [31:0] pc);
        bus.issue_valid   = 1'b1;
        bus.issue_func    = f;
        bus.issue_neg     = neg;
        bus.issue_prf_idx = prf;
        bus.issue_rob_idx = rob;
        bus.issue_PC      = pc;
        op_a              = a;
        op_b              = b;
        tick();
        bus.issue_valid   = 1'b0;
    endtask

    // Issue one op with grant held high and check latency and value.
    task automatic run_op(input string tag, input ALU_FUNC f, input logic neg,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        drive_issue(f, neg, a, b, 6'h2, 5'h1, 32'h2000);
        n = 1;
        while (!bus.cdb_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(MUL_STAGE + 1));
        chk({tag, "_val"}, 64'(bus.cdb_value), 64'(exp));
        tick();
    endtask

    // Wait (bounded) for the next result with grant high, check it, let it pop.
    task automatic expect_result(input string tag, input logic [31:0] v, input logic [5:0] prf);
        int n;
        n = 0;
        while (!bus.cdb_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(bus.cdb_valid), 64'd1);
        chk({tag, "_val"},   64'(bus.cdb_value), 64'(v));
        chk({tag, "_prf"},   64'(bus.cdb_prf_idx), 64'(prf));
        tick();
    endtask

    initial begin
        int issued;
        logic seen;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.squash        = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_func    = ALU_MUL;
        bus.issue_neg     = 1'b0;
        bus.issue_prf_idx = '0;
        bus.issue_rob_idx = '0;
        bus.issue_PC      = '0;
        bus.cdb_grant     = 1'b0;
        op_a   = '0;
        op_b   = '0;
        f_push = 1'b0;
        f_pop  = 1'b0;
        f_data = '0;
        repeat (3) tick();
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        reset = 1'b0;
        tick();

        // 3x5, grant held: visible at cycle 9, gone at cycle 10.
        bus.cdb_grant = 1'b1;
        drive_issue(ALU_MUL, 1'b0, 32'd3, 32'd5, 6'h11, 5'h3, 32'h1000);
        repeat (7) tick();
        chk("t1_early", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t1_val", 64'(bus.cdb_value), 64'h0000000F);
        chk("t1_prf", 64'(bus.cdb_prf_idx), 64'h11);
        chk("t1_rob", 64'(bus.cdb_rob_idx), 64'h3);
        chk("t1_pc", 64'(bus.cdb_PC), 64'h1000);
        tick();
        chk("t1_gone", 64'(bus.cdb_valid), 64'd0);

        // Sign correction and high/low half selection.
        run_op("mulh_neg", ALU_MULH, 1'b1, 32'd2, 32'd3, 32'hFFFFFFFF);
        run_op("mul_neg", ALU_MUL, 1'b1, 32'd2, 32'd3, 32'hFFFFFFFA);
        run_op("mulhu_max", ALU_MULHU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mul_max", ALU_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("mulhsu_neg", ALU_MULHSU, 1'b1, 32'd1, 32'd1, 32'hFFFFFFFF);

        // Credit: grant low, issue whenever allowed.
        bus.cdb_grant = 1'b0;
        issued = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.issue_ready) begin
                bus.issue_valid   = 1'b1;
                bus.issue_func    = ALU_MUL;
                bus.issue_neg     = 1'b0;
                bus.issue_prf_idx = 6'(issued);
                op_a              = 32'(issued + 1);
                op_b              = 32'd7;
                issued++;
            end else begin
                bus.issue_valid = 1'b0;
            end
            tick();
        end
        bus.issue_valid = 1'b0;
        chk("t4_issued", 64'(issued), 64'd4);
        repeat (12) tick();
        chk("t4_ready_full", 64'(bus.issue_ready), 64'd0);
        chk("t4_head", 64'(bus.cdb_value), 64'd7);
        bus.cdb_grant = 1'b1;
        tick();
        bus.cdb_grant = 1'b0;
        chk("t4_ready_after_pop", 64'(bus.issue_ready), 64'd1);
        drive_issue(ALU_MUL, 1'b0, 32'd5, 32'd7, 6'd4, 5'd0, 32'h0);
        bus.cdb_grant = 1'b1;
        expect_result("t4_r1", 32'd14, 6'd1);
        expect_result("t4_r2", 32'd21, 6'd2);
        expect_result("t4_r3", 32'd28, 6'd3);
        expect_result("t4_r4", 32'd35, 6'd4);

        // Squash with one queued and three in flight.
        bus.cdb_grant = 1'b0;
        drive_issue(ALU_MUL, 1'b0, 32'd2, 32'd2, 6'd9, 5'd0, 32'h0);
        repeat (10) tick();
        chk("t5_queued", 64'(bus.cdb_valid), 64'd1);
        drive_issue(ALU_MUL, 1'b0, 32'd3, 32'd3, 6'd10, 5'd0, 32'h0);
        drive_issue(ALU_MUL, 1'b0, 32'd4, 32'd4, 6'd11, 5'd0, 32'h0);
        drive_issue(ALU_MUL, 1'b0, 32'd5, 32'd5, 6'd12, 5'd0, 32'h0);
        bus.squash = 1'b1;
        tick();
        bus.squash = 1'b0;
        chk("t5_valid_cleared", 64'(bus.cdb_valid), 64'd0);
        chk("t5_ready_restored", 64'(bus.issue_ready), 64'd1);
        seen = 1'b0;
        repeat (12) begin
            if (bus.cdb_valid) seen = 1'b1;
            tick();
        end
        chk("t5_stale_dropped", 64'(seen), 64'd0);
        bus.cdb_grant = 1'b1;
        run_op("t5_recover", ALU_MUL, 1'b0, 32'd6, 32'd7, 32'd42);

        // Full queue: push and pop together.
        for (int i = 0; i < 4; i++) begin
            f_push       = 1'b1;
            f_data       = '0;
            f_data.value = 32'h10 + 32'(i);
            tick();
        end
        f_push = 1'b0;
        chk("t6_full_count", 64'(f_count), 64'd4);
        chk("t6_full_head", 64'(f_head.value), 64'h10);
        f_push       = 1'b1;
        f_pop        = 1'b1;
        f_data.value = 32'h14;
        tick();
        f_push = 1'b0;
        f_pop  = 1'b0;
        chk("t6_count_held", 64'(f_count), 64'd4);
        chk("t6_head_adv", 64'(f_head.value), 64'h11);
        f_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_drain", 64'(f_head.value), 64'h11 + 64'(i));
            tick();
        end
        f_pop = 1'b0;
        chk("t6_empty", 64'(f_head_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_cdb_buffer.md
# mul_cdb_buffer

Sits between the pipelined multiplier and the CDB arbiter. It carries each issued multiply's tags (destination PRF index, ROB index, PC, function, sign-correction flag) through a delay line matched to the multiplier latency. It pairs them with the raw 2×XLEN product on `done`, forms the final XLEN-bit result, and queues finished results until the CDB grants a broadcast. It also returns a credit-style `issue_ready` to the multiply reservation station, so no result is ever dropped while the CDB is busy.

## Interface
- `STAGE`, default 8: multiplier latency in cycles, from issue to `mul_done`.
- `DEPTH`, default 4: result queue entries, power of two, at least 2.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `squash`  in  1  pipeline flush; discards all in-flight and queued results.
- `issue_valid`  in  1  a multiply enters the multiplier this cycle.
- `issue_func`  in  `ALU_FUNC`  one of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU.
- `issue_neg`  in  1  the true product is negative; the issue side has already fed magnitudes to the multiplier.
- `issue_prf_idx`  in  `PRF_LEN`; `issue_rob_idx`  in  `ROB_LEN`; `issue_PC`  in  `XLEN`  tags.
- `issue_ready`  out  1  high when an issue this cycle is guaranteed queue space.
- `mul_done`  in  1  multiplier output valid.
- `mul_product`  in  2×XLEN  unsigned magnitude product.
- `cdb_valid`  out  1  queue head holds a result.
- `cdb_value`  out  XLEN  head result.
- `cdb_prf_idx`, `cdb_rob_idx`, `cdb_PC`  out  head tags.
- `cdb_grant`  in  1  CDB broadcasts the head this cycle; pops it.

## Operation
- **Tag pipe.** STAGE-deep shift register of {valid, func, neg, prf, rob, PC}.
  - Slot 0 loads `issue_valid & ~squash` with the issue tags.
  - Every slot shifts each cycle; no stall.
  - The last slot aligns with `mul_done`.
- **Result formation** (combinational at the pipe tail):
  - p = neg ? (~mul_product + 1) : mul_product, in full 2×XLEN.
  - ALU_MUL takes p[XLEN-1:0].
  - ALU_MULH, ALU_MULHSU and ALU_MULHU take p[2×XLEN-1:XLEN].
- **Push.** Push when the tail valid bit is 1, `mul_done` is 1 and `squash` is 0.
  - If `mul_done` is 1 with the tail valid bit 0, the result is discarded. This is the normal outcome after a squash.
  - Tail valid bit 1 with `mul_done` 0 is an assertion failure.
- **Queue.** Circular FIFO with head and tail pointers and a count from 0 to DEPTH. Registered output: the head is presented directly.
  - Pop when `cdb_valid & cdb_grant`.
  - Push and pop in the same cycle are both honored; count is unchanged.
  - Pointers wrap modulo DEPTH.
- **Credit.** `issue_ready` = (count + inflight) < DEPTH, where inflight is the number of set valid bits in the tag pipe.
  - A pop in the current cycle is not credited; this is conservative.
  - Push while count == DEPTH is an assertion failure and is unreachable when the issuer obeys `issue_ready`.
  - Issue while `issue_ready` is 0 is an assertion failure.
- **Squash.** At the next edge, clear all tag-pipe valid bits, count, and both pointers. Any issue, push or pop in that cycle is ignored.

## Timing
- Reset and squash values:
  - `cdb_valid` = 0.
  - `issue_ready` = 1.
  - Pipe valid bits, count and pointers = 0.
  - Data outputs may hold any value while `cdb_valid` = 0.
- Issue in cycle t leads to `mul_done` in cycle t+STAGE, the push at that edge, and `cdb_valid` in cycle t+STAGE+1 when the queue was empty. Total latency from issue to CDB is STAGE+1.
- Back-to-back issues with the grant held high give one result per cycle, in issue order.
- With `cdb_grant` held at 0, at most DEPTH results are accepted. `issue_ready` then stays 0 until a pop has occurred and the pop's edge has passed.
- Reset in the middle of an operation has the same effect as squash. Outstanding multiplier outputs are discarded by the valid-bit check.

## Structure
- Shared package contents:
  - the `MUL_TAG_PACKET` struct (valid, func, neg, prf_idx, rob_idx, PC);
  - the `ALU_FUNC` enum;
  - the XLEN, PRF_LEN, ROB_LEN and MUL_STAGE constants.
- One sub-module, `mul_result_fifo` (parameter DEPTH): push, pop, squash, count and head interface. The tag pipe, result formation and credit logic stay in the top module.

## Test plan
- ALU_MUL 3×5 issued at cycle 0, `cdb_grant` held at 1 → `cdb_valid` high at cycle 9 with value 0x0000000F and matching tags; low at cycle 10.
- ALU_MULH with magnitudes 2 and 3, `issue_neg` = 1 (that is, −2×3) → value 0xFFFFFFFF. The same operation as ALU_MUL → 0xFFFFFFFA.
- ALU_MULHU with 0xFFFFFFFF×0xFFFFFFFF, neg = 0 → 0xFFFFFFFE. ALU_MUL → 0x00000001.
- `cdb_grant` held at 0 while issuing every cycle `issue_ready` allows → `issue_ready` drops after 4 issues. Granting one pop raises it the next cycle. All results come out in order with none lost.
- Squash asserted at cycle 4 with 3 ops in flight and 1 queued → from cycle 5 `cdb_valid` = 0 and `issue_ready` = 1; the stale `mul_done` pulses are dropped.
- A push and a grant in the same cycle with a full queue → count stays at DEPTH, the head advances, and the new entry lands at the tail.
